sdram_burst_ctrl: RTL

SDRAM_BURST_CTRL -- requirements
Module: sdram_burst_ctrl

---
 rtl/sdram_burst_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_burst_ctrl
// Single-burst SDRAM controller. A request opens one row (ACTIVE), issues one
// READ or WRITE, streams the burst, stops it with BURST_TERM, then closes all
// banks with PRECHARGE before accepting the next request.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_req, i_we      : transfer request (taken in IDLE only), 1=write
//   i_addr           : {bank,row,col}
//   i_burst_len      : words in the burst, 0..2^COL_W (clamped to row end)
//   i_wdata          : write word, taken while o_wr_ack=1
//   o_busy           : controller not idle
//   o_wr_ack         : write-data request (combinational)
//   o_rd_valid/data  : read word strobe and data
//   o_done           : one-cycle pulse at end of burst
//   sdr_*            : SDRAM command/address/data pins
// -----------------------------------------------------------------------------
module sdram_burst_ctrl #(
   parameter int DQ_W  = 32,
   parameter int BA_W  = 2,
   parameter int ROW_W = 11,
   parameter int COL_W = 8,
   parameter int T_RCD = 2,
   parameter int T_WR  = 2,
   parameter int T_RP  = 3,
   parameter int CL    = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_req,
   input  logic                          i_we,
   input  logic [BA_W+ROW_W+COL_W-1:0]   i_addr,
   input  logic [COL_W:0]                i_burst_len,
   input  logic [DQ_W-1:0]               i_wdata,
   output logic                          o_busy,
   output logic                          o_wr_ack,
   output logic                          o_rd_valid,
   output logic [DQ_W-1:0]               o_rd_data,
   output logic                          o_done,
   output logic [3:0]                    sdr_cmds,
   output logic [ROW_W-1:0]              sdr_addr,
   output logic [BA_W-1:0]               sdr_ba,
   output logic [DQ_W-1:0]               sdr_dq_out,
   output logic                          sdr_dq_oe,
   input  logic [DQ_W-1:0]               sdr_dq_in,
   output logic [DQ_W/8-1:0]             sdr_dqm
);

   localparam int ADDR_W = BA_W + ROW_W + COL_W;
   localparam int CNT_W  = COL_W + 1;
   localparam int DM_W   = DQ_W / 8;

   // {CS#,RAS#,CAS#,WE#}
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_BTERM = 4'b0110;
   localparam logic [3:0] CMD_PRE   = 4'b0010;

   // Last counter value of each timed wait (counter restarts at 0 per state)
   localparam logic [CNT_W-1:0] RCD_LAST = CNT_W'(T_RCD - 2);
   localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(T_WR - 2);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(CL);
   localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP - 2);

   typedef enum logic [3:0] {
      S_IDLE, S_ACT, S_WAIT_RCD, S_CMD, S_XFER,
      S_BTERM, S_DRAIN, S_PRE, S_WAIT_RP, S_END
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_we;
   logic [CNT_W-1:0]       r_len;
   logic [BA_W-1:0]        r_bank;
   logic [ROW_W-1:0]       r_row;
   logic [COL_W-1:0]       r_col;

   logic [3:0]             r_cmds;
   logic [ROW_W-1:0]       r_sdr_addr;
   logic [BA_W-1:0]        r_sdr_ba;
   logic [DM_W-1:0]        r_dqm;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_dq_oe;
   logic [DQ_W-1:0]        r_dq_out;
   logic                   r_rd_issue;
   logic [CL-1:0]          r_rd_dly;
   logic                   r_rd_valid;
   logic [DQ_W-1:0]        r_rd_data;

   logic [3:0]             w_cmd;
   logic [ROW_W-1:0]       w_addr;
   logic [DM_W-1:0]        w_dqm;
   logic                   w_data_phase;
   logic                   w_wr_ack;
   logic [CNT_W-1:0]       w_len_m2;
   logic [BA_W-1:0]        w_in_bank;
   logic [ROW_W-1:0]       w_in_row;
   logic [COL_W-1:0]       w_in_col;

   // Limit a burst so it never runs past the end of the open row.
   function automatic logic [CNT_W-1:0] clamp_len(input logic [COL_W-1:0] col,
                                                  input logic [CNT_W-1:0] len);
      logic [CNT_W:0] span;
      logic [CNT_W:0] room;
      logic [CNT_W:0] last;
      span = {2'b01, {COL_W{1'b0}}};
      room = span - {2'b00, col};
      last = {2'b00, col} + {1'b0, len};
      if (last > span) return room[CNT_W-1:0];
      return len;
   endfunction

   assign w_in_bank = i_addr[ADDR_W-1 -: BA_W];
   assign w_in_row  = i_addr[COL_W +: ROW_W];
   assign w_in_col  = i_addr[COL_W-1:0];
   assign w_len_m2  = r_len - CNT_W'(2);

   // CMD plus XFER is the data phase; zero-length bursts carry no data.
   assign w_data_phase = ((r_state == S_CMD) || (r_state == S_XFER)) && (r_len != '0);
   assign w_wr_ack     = w_data_phase && r_we;
   assign o_wr_ack     = w_wr_ack;

   // ---- state register, shared counter, request latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_len   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
         if (r_state == S_IDLE && i_req) begin
            r_we  <= i_we;
            r_len <= clamp_len(w_in_col, i_burst_len);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && i_req) begin
         r_bank <= w_in_bank;
         r_row  <= w_in_row;
         r_col  <= w_in_col;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (i_req) w_state_nxt = S_ACT;
         S_ACT:      w_state_nxt = S_WAIT_RCD;
         S_WAIT_RCD: if (r_cnt == RCD_LAST) w_state_nxt = S_CMD;
         S_CMD:      w_state_nxt = (r_len < CNT_W'(2)) ? S_BTERM : S_XFER;
         S_XFER:     if (r_cnt == w_len_m2) w_state_nxt = S_BTERM;
         S_BTERM:    w_state_nxt = S_DRAIN;
         S_DRAIN:    if (r_cnt == (r_we ? WR_LAST : RD_LAST)) w_state_nxt = S_PRE;
         S_PRE:      w_state_nxt = S_WAIT_RP;
         S_WAIT_RP:  if (r_cnt == RP_LAST) w_state_nxt = S_END;
         S_END:      w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Pin values decoded from the current state; registered one cycle later.
   always_comb begin
      w_cmd  = CMD_NOP;
      w_addr = '0;
      w_dqm  = '0;
      case (r_state)
         S_IDLE:     w_dqm  = '1;
         S_ACT:      begin w_cmd = CMD_ACT; w_addr = r_row; end
         S_WAIT_RCD: w_addr = r_row;
         S_CMD:      begin
                        w_cmd  = r_we ? CMD_WRITE : CMD_READ;
                        w_addr = {{(ROW_W-COL_W){1'b0}}, r_col};
                     end
         S_XFER,
         S_DRAIN:    w_addr = {{(ROW_W-COL_W){1'b0}}, r_col};
         S_BTERM:    begin
                        w_cmd  = CMD_BTERM;
                        w_addr = {{(ROW_W-COL_W){1'b0}}, r_col};
                     end
         S_PRE:      begin w_cmd = CMD_PRE; w_addr = '1; end
         S_WAIT_RP:  w_addr = '1;
         S_END:      begin w_addr = '1; w_dqm = '1; end
         default:    w_dqm  = '1;
      endcase
   end

   // ---- output stage: pins, write data, read pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmds     <= CMD_NOP;
         r_sdr_addr <= '1;
         r_sdr_ba   <= '0;
         r_dqm      <= '1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_dq_oe    <= 1'b0;
         r_dq_out   <= '0;
         r_rd_issue <= 1'b0;
         r_rd_dly   <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_cmds     <= w_cmd;
         r_sdr_addr <= w_addr;
         r_sdr_ba   <= (r_state == S_IDLE) ? '0 : r_bank;
         r_dqm      <= w_dqm;
         r_busy     <= (r_state != S_IDLE);
         r_done     <= (r_state == S_END);
         r_dq_oe    <= w_wr_ack;
         r_dq_out   <= w_wr_ack ? i_wdata : '0;
         // Issue flag lines up with READ on the pins; CL-stage delay marks
         // the cycles in which the device returns data.
         r_rd_issue <= w_data_phase && !r_we;
         r_rd_dly   <= {r_rd_dly[CL-2:0], r_rd_issue};
         r_rd_valid <= r_rd_dly[CL-1];
         if (r_rd_dly[CL-1]) r_rd_data <= sdr_dq_in;
      end
   end

   assign sdr_cmds   = r_cmds;
   assign sdr_addr   = r_sdr_addr;
   assign sdr_ba     = r_sdr_ba;
   assign sdr_dqm    = r_dqm;
   assign sdr_dq_oe  = r_dq_oe;
   assign sdr_dq_out = r_dq_out;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_rd_valid = r_rd_valid;
   assign o_rd_data  = r_rd_data;

endmodule
